// File: rtl/unified_mem_arbiter.sv
// Arbitrates one multi-cycle unified memory port between instruction fetch and data accesses.
// Data wins by default; fetch gets a forced grant after MAX_STARVE consecutive losses.
module unified_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_data,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          err
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] starve_cnt_r, starve_cnt_s;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
  logic          drain_r, drain_s;
  logic          mem_req_s, mem_wr_s, if_done_s, dm_done_s, err_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s, if_data_s, dm_rdata_s;
  logic          dm_req_s, fetch_win_s;

  assign dm_req_s    = dm_rd | dm_wr;
  assign fetch_win_s = if_req & (~dm_req_s | (starve_cnt_r == SW'(MAX_STARVE)));
  assign if_stall    = if_req & ~if_done;
  assign dm_stall    = dm_req_s & ~dm_done;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = starve_cnt_r;
    tmo_cnt_s    = tmo_cnt_r;
    drain_s      = drain_r;
    mem_req_s    = 1'b0;
    mem_wr_s     = mem_wr;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    if_data_s    = if_data;
    dm_rdata_s   = dm_rdata;
    if_done_s    = 1'b0;
    dm_done_s    = 1'b0;
    err_s        = err;
    case (state_r)
      IDLE: begin
        // A response still in flight across a reset is swallowed once without error.
        if (mem_done) begin
          if (drain_r) begin
            drain_s = 1'b0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          drain_s = drain_r;
        end
        // The done-pulse cycle is skipped so the finishing requester can drop its request.
        if (if_done | dm_done) begin
          state_s = IDLE;
        end else if (fetch_win_s) begin
          state_s      = BUSY_I;
          mem_req_s    = 1'b1;
          mem_wr_s     = 1'b0;
          mem_addr_s   = if_addr;
          tmo_cnt_s    = {TW{1'b0}};
          starve_cnt_s = {SW{1'b0}};
          drain_s      = 1'b0;
          err_s        = err_s | if_addr[0];
        end else if (dm_req_s) begin
          state_s     = BUSY_D;
          mem_req_s   = 1'b1;
          mem_wr_s    = dm_wr;
          mem_addr_s  = dm_addr;
          mem_wdata_s = dm_wdata;
          tmo_cnt_s   = {TW{1'b0}};
          drain_s     = 1'b0;
          err_s       = err_s | dm_addr[0] | (dm_rd & dm_wr);
          if (if_req && (starve_cnt_r != SW'(MAX_STARVE))) begin
            starve_cnt_s = starve_cnt_r + SW'(1);
          end else begin
            starve_cnt_s = starve_cnt_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I: begin
        if (mem_done) begin
          state_s   = IDLE;
          if_data_s = mem_rdata;
          if_done_s = 1'b1;
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      BUSY_D: begin
        if (mem_done) begin
          state_s   = IDLE;
          dm_done_s = 1'b1;
          if (!mem_wr) begin
            dm_rdata_s = mem_rdata;
          end else begin
            dm_rdata_s = dm_rdata;
          end
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= {SW{1'b0}};
      tmo_cnt_r    <= {TW{1'b0}};
      drain_r      <= 1'b1;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= {AW{1'b0}};
      mem_wdata    <= {DW{1'b0}};
      if_data      <= {DW{1'b0}};
      dm_rdata     <= {DW{1'b0}};
      if_done      <= 1'b0;
      dm_done      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      tmo_cnt_r    <= tmo_cnt_s;
      drain_r      <= drain_s;
      mem_req      <= mem_req_s;
      mem_wr       <= mem_wr_s;
      mem_addr     <= mem_addr_s;
      mem_wdata    <= mem_wdata_s;
      if_data      <= if_data_s;
      dm_rdata     <= dm_rdata_s;
      if_done      <= if_done_s;
      dm_done      <= dm_done_s;
      err          <= err_s;
    end
  end

endmodule
